cacheline_adapter: RTL and testbench

- Sits directly downstream of the pipelined cache's dfp (downstream-facing port); converts one 256-bit cacheline read or write into 64-bit burst transactions on the burst memory (bmem) interface.
- Returns a single-cycle dfp_resp per completed line transfer.
- The cache holds dfp_read / dfp_write / dfp_addr / dfp_wdata stable from assertion until it sees dfp_resp.

---
 rtl/rv32im_types.sv | 20 ++
 rtl/line_beat_buffer.sv | 48 ++++
 rtl/cacheline_adapter.sv | 133 +++++++++++++
 tb/tb_cacheline_adapter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32im_types.sv
// Shared types and constants for the rv32im memory subsystem.
// The cacheline adapter uses these constants for its line and beat widths and its FSM state enum.
package rv32im_types;

  localparam int CACHELINE_W   = 256;
  localparam int BMEM_BEAT_W   = 64;
  localparam int BMEM_BEATS    = CACHELINE_W / BMEM_BEAT_W;
  localparam int LINE_OFFSET_W = 5;
  localparam int BEAT_IDX_W    = 2;

  typedef enum logic [2:0] {
    IDLE,
    WR_BURST,
    RD_REQ,
    RD_WAIT,
    RESP,
    DONE
  } adapter_state_t;

endpackage

// File: rtl/line_beat_buffer.sv
// Beat-addressed line storage for the cacheline adapter.
// It holds the fill line, which the adapter assembles in place one beat per bmem_rvalid.
// It holds the latched writeback line, which is serialised one beat at a time.
// It also holds the shared 2-bit beat counter used by both directions.
module line_beat_buffer
  import rv32im_types::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear_cnt,
  input  logic                   load_wline,
  input  logic [CACHELINE_W-1:0] wline,
  input  logic                   advance,
  input  logic                   fill_we,
  input  logic [BMEM_BEAT_W-1:0] fill_beat,
  output logic [CACHELINE_W-1:0] fill_line,
  output logic [BMEM_BEAT_W-1:0] send_beat,
  output logic                   last_beat
);

  logic [BEAT_IDX_W-1:0]                  beat_cnt;
  logic [BMEM_BEATS-1:0][BMEM_BEAT_W-1:0] fill_q;
  logic [BMEM_BEATS-1:0][BMEM_BEAT_W-1:0] wline_q;

  // Beat counter: cleared at burst start, steps on each accepted write beat or stored read beat, wraps 3->0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  beat_cnt <= '0;
    else if (clear_cnt)          beat_cnt <= '0;
    else if (advance || fill_we) beat_cnt <= beat_cnt + 1'b1;
  end

  // Writeback line snapshot, taken when the write burst is launched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          wline_q <= '0;
    else if (load_wline) wline_q <= wline;
  end

  // Fill line assembled in place; untouched slots keep the previous line's data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       fill_q <= '0;
    else if (fill_we) fill_q[beat_cnt] <= fill_beat;
  end

  assign fill_line = fill_q;
  assign send_beat = wline_q[beat_cnt];
  assign last_beat = (beat_cnt == BEAT_IDX_W'(BMEM_BEATS - 1));

endmodule

// File: rtl/cacheline_adapter.sv
// Converts one 256-bit cacheline read or write from the cache dfp into 64-bit bmem bursts.
// Writeback has priority over fill, so a dirty miss writes back before it fills.
// Optional feature: define CACHELINE_ADAPTER_ADDR_CHECK_EN to compare each read beat's bmem_raddr
// with the requested line address and raise a sticky err on mismatch.
module cacheline_adapter
  import rv32im_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = CACHELINE_W,
  parameter int BEAT_W = BMEM_BEAT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] dfp_addr,
  input  logic              dfp_read,
  input  logic              dfp_write,
  input  logic [LINE_W-1:0] dfp_wdata,
  output logic [LINE_W-1:0] dfp_rdata,
  output logic              dfp_resp,
  output logic [ADDR_W-1:0] bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [ADDR_W-1:0] bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid,
  output logic              err
);

  adapter_state_t    state, next_state;
  logic [ADDR_W-1:0] addr_q;
  logic              latch_addr;
  logic              clear_cnt;
  logic              load_wline;
  logic              advance;
  logic              fill_we;
  logic              last_beat;
  logic [BEAT_W-1:0] send_beat;
  logic              unused_bits;

  line_beat_buffer u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_cnt  (clear_cnt),
    .load_wline (load_wline),
    .wline      (dfp_wdata),
    .advance    (advance),
    .fill_we    (fill_we),
    .fill_beat  (bmem_rdata),
    .fill_line  (dfp_rdata),
    .send_beat  (send_beat),
    .last_beat  (last_beat)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Line-aligned request address, captured when a burst is launched from IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          addr_q <= '0;
    else if (latch_addr) addr_q <= {dfp_addr[ADDR_W-1:LINE_OFFSET_W], LINE_OFFSET_W'(0)};
  end

  // Next-state and handshake decode; DONE deliberately ignores a request the cache is still holding
  always_comb begin
    next_state = state;
    latch_addr = 1'b0;
    clear_cnt  = 1'b0;
    load_wline = 1'b0;
    advance    = 1'b0;
    fill_we    = 1'b0;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    dfp_resp   = 1'b0;
    unique case (state)
      IDLE: begin
        if (dfp_write) begin
          next_state = WR_BURST;
          latch_addr = 1'b1;
          clear_cnt  = 1'b1;
          load_wline = 1'b1;
        end else if (dfp_read) begin
          next_state = RD_REQ;
          latch_addr = 1'b1;
          clear_cnt  = 1'b1;
        end
      end
      WR_BURST: begin
        bmem_write = 1'b1;
        if (bmem_ready) begin
          advance = 1'b1;
          if (last_beat) next_state = RESP;
        end
      end
      RD_REQ: begin
        bmem_read = 1'b1;
        if (bmem_ready) next_state = RD_WAIT;
      end
      RD_WAIT: begin
        if (bmem_rvalid) begin
          fill_we = 1'b1;
          if (last_beat) next_state = RESP;
        end
      end
      RESP: begin
        dfp_resp   = 1'b1;
        next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign bmem_addr  = (state == WR_BURST || state == RD_REQ) ? addr_q : '0;
  assign bmem_wdata = (state == WR_BURST) ? send_beat : '0;

`ifdef CACHELINE_ADAPTER_ADDR_CHECK_EN
  // Sticky flag for a read beat tagged with an address other than the requested line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                   err <= 1'b0;
    else if (state == RD_WAIT && bmem_rvalid && bmem_raddr != addr_q) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

  assign unused_bits = ^{dfp_addr[LINE_OFFSET_W-1:0], bmem_raddr};

endmodule

// File: tb/tb_cacheline_adapter.sv
// Self-checking bench for cacheline_adapter.
// A vector table covers a plain write, a gapped read, stray beats and dfp_rdata retention.
// Hand-written sequences cover backpressure, a dirty miss, async reset mid-burst and the address check.
module tb_cacheline_adapter;

  logic         clk;
  logic         rst_n;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;
  logic         err;

`ifdef CACHELINE_ADAPTER_ADDR_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic        ready;
    logic        rvalid;
    logic [63:0] rbeat;
    logic        e_bwrite;
    logic        e_bread;
    logic [31:0] e_baddr;
    logic [63:0] e_bwdata;
    logic        e_resp;
    logic        chk_rdata;
    logic [255:0] e_rdata;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   errors;
  int   resp_count;

  cacheline_adapter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dfp_addr    (dfp_addr),
    .dfp_read    (dfp_read),
    .dfp_write   (dfp_write),
    .dfp_wdata   (dfp_wdata),
    .dfp_rdata   (dfp_rdata),
    .dfp_resp    (dfp_resp),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_write  (bmem_write),
    .bmem_wdata  (bmem_wdata),
    .bmem_ready  (bmem_ready),
    .bmem_raddr  (bmem_raddr),
    .bmem_rdata  (bmem_rdata),
    .bmem_rvalid (bmem_rvalid),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial resp_count = 0;
  always @(negedge clk) if (dfp_resp) resp_count <= resp_count + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [255:0] actual, input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    dfp_write   = v.wr;
    dfp_read    = v.rd;
    dfp_addr    = v.addr;
    bmem_ready  = v.ready;
    bmem_rvalid = v.rvalid;
    bmem_rdata  = v.rbeat;
    bmem_raddr  = {v.addr[31:5], 5'b0};
    tick();
  endtask

  task automatic rd_beat(input logic [63:0] d);
    bmem_rvalid = 1'b1;
    bmem_rdata  = d;
    tick();
    bmem_rvalid = 1'b0;
    bmem_rdata  = '0;
  endtask

  function automatic void add_vec(input logic wr, input logic rd, input logic [31:0] addr,
                                  input logic ready, input logic rvalid, input logic [63:0] rbeat,
                                  input logic e_bwrite, input logic e_bread, input logic [31:0] e_baddr,
                                  input logic [63:0] e_bwdata, input logic e_resp,
                                  input logic chk_rdata, input logic [255:0] e_rdata);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = addr; v.ready = ready; v.rvalid = rvalid; v.rbeat = rbeat;
    v.e_bwrite = e_bwrite; v.e_bread = e_bread; v.e_baddr = e_baddr; v.e_bwdata = e_bwdata;
    v.e_resp = e_resp; v.chk_rdata = chk_rdata; v.e_rdata = e_rdata;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [63:0]  d0, d1, d2, d3, aa, bb, cc, dd, ee;
    logic [63:0]  e0, e1, e2, e3, m0, m1, m2, m3, r0, r1, n0, n1, n2, n3;
    logic [255:0] wline, rline, eline;
    logic [31:0]  wa, wb, ra;
    logic [63:0]  accepted[$];
    int           c, base;

    checks = 0;
    errors = 0;
    d0 = 64'hD0D0_0000_0000_0010; d1 = 64'hD1D1_0000_0000_0011;
    d2 = 64'hD2D2_0000_0000_0012; d3 = 64'hD3D3_0000_0000_0013;
    aa = 64'hAAAA_AAAA_AAAA_AAAA; bb = 64'hBBBB_BBBB_BBBB_BBBB;
    cc = 64'hCCCC_CCCC_CCCC_CCCC; dd = 64'hDDDD_DDDD_DDDD_DDDD;
    ee = 64'hEEEE_EEEE_EEEE_EEEE;
    e0 = 64'hE000_0000_0000_0100; e1 = 64'hE111_0000_0000_0101;
    e2 = 64'hE222_0000_0000_0102; e3 = 64'hE333_0000_0000_0103;
    m0 = 64'h0000_0000_0000_0001; m1 = 64'h0000_0000_0000_0002;
    m2 = 64'h0000_0000_0000_0003; m3 = 64'h0000_0000_0000_0004;
    r0 = 64'h5150_0000_0000_0000; r1 = 64'h5151_0000_0000_0000;
    n0 = 64'h4000_0000_0000_00A0; n1 = 64'h4000_0000_0000_00A1;
    n2 = 64'h4000_0000_0000_00A2; n3 = 64'h4000_0000_0000_00A3;
    wline = {d3, d2, d1, d0};
    rline = {dd, cc, bb, aa};
    eline = {e3, e2, e1, e0};
    wa = 32'h0000_1234;
    wb = 32'h0000_1220;
    ra = 32'h8000_0040;

    // write burst, read with a gap, stray beats, rdata retention across a write
    add_vec(1'b1,1'b0,wa,1'b1,1'b0,'0, 1'b1,1'b0,wb,d0,1'b0,1'b0,'0);
    add_vec(1'b1,1'b0,wa,1'b1,1'b0,'0, 1'b1,1'b0,wb,d1,1'b0,1'b0,'0);
    add_vec(1'b1,1'b0,wa,1'b1,1'b0,'0, 1'b1,1'b0,wb,d2,1'b0,1'b0,'0);
    add_vec(1'b1,1'b0,wa,1'b1,1'b0,'0, 1'b1,1'b0,wb,d3,1'b0,1'b0,'0);
    add_vec(1'b1,1'b0,wa,1'b1,1'b0,'0, 1'b0,1'b0,'0,'0,1'b1,1'b1,'0);
    add_vec(1'b1,1'b0,wa,1'b1,1'b0,'0, 1'b0,1'b0,'0,'0,1'b0,1'b0,'0);
    add_vec(1'b0,1'b0,wa,1'b1,1'b0,'0, 1'b0,1'b0,'0,'0,1'b0,1'b0,'0);
    add_vec(1'b0,1'b1,ra,1'b1,1'b0,'0, 1'b0,1'b1,ra,'0,1'b0,1'b0,'0);
    add_vec(1'b0,1'b1,ra,1'b1,1'b0,'0, 1'b0,1'b0,'0,'0,1'b0,1'b0,'0);
    add_vec(1'b0,1'b1,ra,1'b1,1'b1,aa, 1'b0,1'b0,'0,'0,1'b0,1'b0,'0);
    add_vec(1'b0,1'b1,ra,1'b1,1'b1,bb, 1'b0,1'b0,'0,'0,1'b0,1'b0,'0);
    add_vec(1'b0,1'b1,ra,1'b1,1'b0,'0, 1'b0,1'b0,'0,'0,1'b0,1'b0,'0);
    add_vec(1'b0,1'b1,ra,1'b1,1'b1,cc, 1'b0,1'b0,'0,'0,1'b0,1'b0,'0);
    add_vec(1'b0,1'b1,ra,1'b1,1'b1,dd, 1'b0,1'b0,'0,'0,1'b1,1'b1,rline);
    add_vec(1'b0,1'b1,ra,1'b1,1'b1,ee, 1'b0,1'b0,'0,'0,1'b0,1'b1,rline);
    add_vec(1'b0,1'b0,ra,1'b1,1'b1,ee, 1'b0,1'b0,'0,'0,1'b0,1'b1,rline);
    add_vec(1'b1,1'b0,wa,1'b1,1'b0,'0, 1'b1,1'b0,wb,d0,1'b0,1'b1,rline);
    add_vec(1'b1,1'b0,wa,1'b1,1'b0,'0, 1'b1,1'b0,wb,d1,1'b0,1'b0,'0);
    add_vec(1'b1,1'b0,wa,1'b1,1'b0,'0, 1'b1,1'b0,wb,d2,1'b0,1'b0,'0);
    add_vec(1'b1,1'b0,wa,1'b1,1'b0,'0, 1'b1,1'b0,wb,d3,1'b0,1'b0,'0);
    add_vec(1'b1,1'b0,wa,1'b1,1'b0,'0, 1'b0,1'b0,'0,'0,1'b1,1'b1,rline);
    add_vec(1'b0,1'b0,wa,1'b1,1'b0,'0, 1'b0,1'b0,'0,'0,1'b0,1'b0,'0);
    add_vec(1'b0,1'b0,wa,1'b1,1'b0,'0, 1'b0,1'b0,'0,'0,1'b0,1'b0,'0);

    rst_n = 1'b0; dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = wline;
    bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
    #12;
    check_output("rst_bwrite", 256'(bmem_write), 256'(1'b0));
    check_output("rst_bread",  256'(bmem_read),  256'(1'b0));
    check_output("rst_resp",   256'(dfp_resp),   256'(1'b0));
    check_output("rst_baddr",  256'(bmem_addr),  256'(32'h0));
    check_output("rst_bwdata", 256'(bmem_wdata), 256'(64'h0));
    check_output("rst_rdata",  dfp_rdata,        256'(0));
    check_output("rst_err",    256'(err),        256'(1'b0));
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("v%0d_bwrite", i), 256'(bmem_write), 256'(vecs[i].e_bwrite));
      check_output($sformatf("v%0d_bread", i),  256'(bmem_read),  256'(vecs[i].e_bread));
      check_output($sformatf("v%0d_baddr", i),  256'(bmem_addr),  256'(vecs[i].e_baddr));
      check_output($sformatf("v%0d_bwdata", i), 256'(bmem_wdata), 256'(vecs[i].e_bwdata));
      check_output($sformatf("v%0d_resp", i),   256'(dfp_resp),   256'(vecs[i].e_resp));
      check_output($sformatf("v%0d_err", i),    256'(err),        256'(1'b0));
      if (vecs[i].chk_rdata)
        check_output($sformatf("v%0d_rdata", i), dfp_rdata, vecs[i].e_rdata);
    end
    bmem_rvalid = 1'b0;

    // backpressure: bmem_ready low for three cycles while beat 1 is presented
    dfp_wdata = eline; dfp_addr = 32'h0000_0100; dfp_write = 1'b1; bmem_ready = 1'b1;
    tick();
    c = 0;
    accepted.delete();
    while (!dfp_resp && c < 20) begin
      bmem_ready = (c >= 1 && c <= 3) ? 1'b0 : 1'b1;
      if (c >= 1 && c <= 3) check_output($sformatf("bp_hold%0d", c), 256'(bmem_wdata), 256'(e1));
      if (bmem_write && bmem_ready) accepted.push_back(bmem_wdata);
      tick();
      c++;
    end
    check_output("bp_cycles", 256'(c), 256'(7));
    check_output("bp_nbeats", 256'(accepted.size()), 256'(4));
    if (accepted.size() == 4) begin
      check_output("bp_beat0", 256'(accepted[0]), 256'(e0));
      check_output("bp_beat1", 256'(accepted[1]), 256'(e1));
      check_output("bp_beat2", 256'(accepted[2]), 256'(e2));
      check_output("bp_beat3", 256'(accepted[3]), 256'(e3));
    end
    dfp_write = 1'b0; bmem_ready = 1'b1;
    tick();
    tick();

    // dirty miss: write and read together, both held one cycle past the first response
    base = resp_count;
    dfp_addr = 32'h0000_0200; dfp_wdata = wline; dfp_write = 1'b1; dfp_read = 1'b1;
    bmem_raddr = 32'h0000_0200;
    tick();
    check_output("dm_write_first", 256'(bmem_write), 256'(1'b1));
    check_output("dm_read_later",  256'(bmem_read),  256'(1'b0));
    tick(); tick(); tick(); tick();
    check_output("dm_resp1", 256'(dfp_resp), 256'(1'b1));
    tick();
    check_output("dm_done_bwrite", 256'(bmem_write), 256'(1'b0));
    check_output("dm_done_bread",  256'(bmem_read),  256'(1'b0));
    dfp_write = 1'b0;
    tick();
    check_output("dm_idle_bread", 256'(bmem_read), 256'(1'b0));
    tick();
    check_output("dm_rdreq", 256'(bmem_read), 256'(1'b1));
    check_output("dm_raddr", 256'(bmem_addr), 256'(32'h0000_0200));
    tick();
    rd_beat(m0); rd_beat(m1); rd_beat(m2); rd_beat(m3);
    check_output("dm_resp2", 256'(dfp_resp), 256'(1'b1));
    check_output("dm_rdata", dfp_rdata, {m3, m2, m1, m0});
    tick();
    dfp_read = 1'b0;
    tick(); tick();
    check_output("dm_resp_count", 256'(resp_count - base), 256'(2));

    // async reset after two read beats, then a clean read
    base = resp_count;
    dfp_addr = 32'h0000_0300; dfp_read = 1'b1; bmem_raddr = 32'h0000_0300;
    tick(); tick();
    rd_beat(r0); rd_beat(r1);
    #2;
    check_output("ar_partial", dfp_rdata, {m3, m2, r1, r0});
    dfp_read = 1'b0;
    rst_n = 1'b0;
    #1;
    check_output("ar_rdata", dfp_rdata, 256'(0));
    check_output("ar_bread", 256'(bmem_read), 256'(1'b0));
    check_output("ar_baddr", 256'(bmem_addr), 256'(32'h0));
    tick();
    check_output("ar_no_resp", 256'(resp_count - base), 256'(0));
    #2;
    rst_n = 1'b1;
    dfp_addr = 32'h0000_0400; dfp_read = 1'b1; bmem_raddr = 32'h0000_0400;
    tick();
    check_output("ar_rdreq", 256'(bmem_read), 256'(1'b1));
    check_output("ar_raddr", 256'(bmem_addr), 256'(32'h0000_0400));
    tick();
    rd_beat(n0); rd_beat(n1); rd_beat(n2); rd_beat(n3);
    check_output("ar_resp", 256'(dfp_resp), 256'(1'b1));
    check_output("ar_newline", dfp_rdata, {n3, n2, n1, n0});
    tick();
    dfp_read = 1'b0;
    tick();

    // beat 3 tagged with a different line address
    dfp_addr = 32'h0000_0040; dfp_read = 1'b1; bmem_raddr = 32'h0000_0040;
    tick(); tick();
    rd_beat(aa); rd_beat(bb); rd_beat(cc);
    check_output("ac_err_before", 256'(err), 256'(1'b0));
    bmem_raddr = 32'h0000_0060;
    rd_beat(dd);
    check_output("ac_resp", 256'(dfp_resp), 256'(1'b1));
    check_output("ac_err", 256'(err), 256'(ERR_EXP));
    check_output("ac_rdata", dfp_rdata, rline);
    tick();
    dfp_read = 1'b0;
    tick(); tick();
    check_output("ac_err_sticky", 256'(err), 256'(ERR_EXP));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
